// File: rtl/byte_unstriping.sv
// -----------------------------------------------------------------------------
// byte_unstriping
//
// Receive-side partner of the 4-lane byte striper. Each time the striper
// raises byteStripingVLD (rising edge only), the four lane bytes are captured
// as one 32-bit word into a small word FIFO. A two-state serializer
// (IDLE / SHIFT) pops words from the FIFO and emits them one byte per clock,
// lane 0 first, lane 3 last.
//
// Output handshake: byteUnstripingVLD is a pure valid strobe with no ready
// back-pressure. A byte is transferred on every clock where
// byteUnstripingVLD==1. The consumer throttles the stream only through ENB.
// While ENB==0, byteUnstripingVLD is 0 and byteUnstripingOUT / laneIndex
// hold their last values.
//
// Optional feature (macro UNSTRIPE_PARITY_EN):
//   When defined, adds parityOUT. This is the even-parity (XOR) bit of
//   byteUnstripingOUT, registered with the data. It is 0 in reset and holds
//   together with the data during stalls.
//
// Parameters:
//   DEPTH  FIFO depth in 32-bit words (power of two, 2..8)
//   CNT_W  width of fifoCount (must represent 0..DEPTH)
//
// Ports:
//   clk1Mhz            in   single clock, all logic on posedge
//   reset              in   synchronous, active-low (0 = reset)
//   ENB                in   serializer enable, 0 stalls byte output
//   stripedLane0..3    in   lane bytes, lane 0 is emitted first
//   byteStripingVLD    in   word-complete flag from the striper
//   byteUnstripingOUT  out  serialised byte
//   byteUnstripingVLD  out  byteUnstripingOUT valid this cycle
//   laneIndex          out  lane the current output byte came from
//   fifoCount          out  words currently stored, 0..DEPTH
//   overflow           out  sticky, a word was dropped on a full FIFO
//   parityOUT          out  (UNSTRIPE_PARITY_EN only) XOR of byteUnstripingOUT
// -----------------------------------------------------------------------------
module byte_unstriping #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk1Mhz,
    input  logic             reset,
    input  logic             ENB,
    input  logic [7:0]       stripedLane0,
    input  logic [7:0]       stripedLane1,
    input  logic [7:0]       stripedLane2,
    input  logic [7:0]       stripedLane3,
    input  logic             byteStripingVLD,
    output logic [7:0]       byteUnstripingOUT,
    output logic             byteUnstripingVLD,
    output logic [1:0]       laneIndex,
    output logic [CNT_W-1:0] fifoCount,
    output logic             overflow
`ifdef UNSTRIPE_PARITY_EN
    ,
    output logic             parityOUT
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Serializer state and output registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  out_q, out_d;
    logic        out_vld_q, out_vld_d;
    logic [1:0]  lane_q, lane_d;
`ifdef UNSTRIPE_PARITY_EN
    logic        parity_q;
`endif

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    // Previous byteStripingVLD, used to detect the rising edge.
    logic             vld_prev_q;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [31:0]      head_word;

    // The striper may hold VLD high for several cycles. Only the 0->1
    // transition marks a new word.
    assign push_req   = byteStripingVLD & ~vld_prev_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign head_word  = mem[rd_ptr_q];

    // A full FIFO still accepts a word when the serializer pops on the same
    // edge. That slot is read (old contents) before it is overwritten.
    assign push_ok = push_req & (~fifo_full | pop);

    function automatic logic [7:0] lane_byte(input logic [31:0] w,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Serializer next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        out_d     = out_q;
        lane_d    = lane_q;
        out_vld_d = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                // FIFO contents are read only after they are registered, so a
                // word pushed on this edge waits for the next edge.
                if (ENB && !fifo_empty) begin
                    pop       = 1'b1;
                    word_d    = head_word;
                    out_d     = head_word[7:0];
                    lane_d    = 2'd0;
                    cnt_d     = 2'd0;
                    out_vld_d = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (ENB) begin
                    if (cnt_q != 2'd3) begin
                        cnt_d     = cnt_q + 2'd1;
                        out_d     = lane_byte(word_q, cnt_q + 2'd1);
                        lane_d    = cnt_q + 2'd1;
                        out_vld_d = 1'b1;
                    end else if (!fifo_empty) begin
                        // Last lane just went out. Load the next word
                        // immediately so the byte stream has no gap.
                        pop       = 1'b1;
                        word_d    = head_word;
                        out_d     = head_word[7:0];
                        lane_d    = 2'd0;
                        cnt_d     = 2'd0;
                        out_vld_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // ENB==0: everything holds, VLD drops (defaults above).
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk1Mhz) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            word_q    <= 32'h0;
            out_q     <= 8'h00;
            out_vld_q <= 1'b0;
            lane_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            lane_q    <= lane_d;
        end
    end

`ifdef UNSTRIPE_PARITY_EN
    // out_d equals out_q during stalls, so parity holds with the data.
    always_ff @(posedge clk1Mhz) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^out_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FIFO control: pointers, occupancy, edge detect, sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk1Mhz) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            vld_prev_q <= 1'b0;
        end else begin
            vld_prev_q <= byteStripingVLD;

            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage has no reset. Entries are only read after they are written.
    always_ff @(posedge clk1Mhz) begin
        if (reset && push_ok) begin
            mem[wr_ptr_q] <= {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign byteUnstripingOUT = out_q;
    assign byteUnstripingVLD = out_vld_q;
    assign laneIndex         = lane_q;
    assign fifoCount         = count_q;
    assign overflow          = overflow_q;
`ifdef UNSTRIPE_PARITY_EN
    assign parityOUT         = parity_q;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// -----------------------------------------------------------------------------
// tb_byte_unstriping
//
// Testbench for byte_unstriping (DEPTH=2).
//
// Stimulus changes just after each falling edge. The DUT samples it on the
// next rising edge, and outputs are read at the following falling edge.
//
// Expected bytes come from a word-level model. Each word accepted by the
// FIFO expands to four {lane, byte} entries in exp_q, in lane order.
//
// Expected FIFO occupancy is "words pushed minus words whose lane 0 has
// appeared on the output".
// -----------------------------------------------------------------------------
module tb_byte_unstriping;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk1Mhz = 1'b0;
    always #5 clk1Mhz = ~clk1Mhz;

    logic             reset;
    logic             ENB;
    logic [7:0]       stripedLane0;
    logic [7:0]       stripedLane1;
    logic [7:0]       stripedLane2;
    logic [7:0]       stripedLane3;
    logic             byteStripingVLD;
    logic [7:0]       byteUnstripingOUT;
    logic             byteUnstripingVLD;
    logic [1:0]       laneIndex;
    logic [CNT_W-1:0] fifoCount;
    logic             overflow;
`ifdef UNSTRIPE_PARITY_EN
    logic             parityOUT;
`endif

    byte_unstriping #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk1Mhz           (clk1Mhz),
        .reset             (reset),
        .ENB               (ENB),
        .stripedLane0      (stripedLane0),
        .stripedLane1      (stripedLane1),
        .stripedLane2      (stripedLane2),
        .stripedLane3      (stripedLane3),
        .byteStripingVLD   (byteStripingVLD),
        .byteUnstripingOUT (byteUnstripingOUT),
        .byteUnstripingVLD (byteUnstripingVLD),
        .laneIndex         (laneIndex),
        .fifoCount         (fifoCount),
        .overflow          (overflow)
`ifdef UNSTRIPE_PARITY_EN
        ,
        .parityOUT         (parityOUT)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_lane0 = 0;

    logic [9:0] exp_q[$];      // {lane, byte}
    logic [9:0] got_q[$];      // {lane, byte}
    int         got_cyc[$];
    logic       got_par_q[$];

    // Passive output capture
    always @(negedge clk1Mhz) begin
        cyc++;
        if (byteUnstripingVLD === 1'b1) begin
            got_q.push_back({laneIndex, byteUnstripingOUT});
            got_cyc.push_back(cyc);
            if (laneIndex == 2'd0) n_lane0++;
`ifdef UNSTRIPE_PARITY_EN
            got_par_q.push_back(parityOUT);
`else
            got_par_q.push_back(1'b0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks and reference model
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk1Mhz);
            #1;
        end
    endtask

    task automatic drive_word(input logic [31:0] w);
        stripedLane0    = w[7:0];
        stripedLane1    = w[15:8];
        stripedLane2    = w[23:16];
        stripedLane3    = w[31:24];
        byteStripingVLD = 1'b1;
    endtask

    task automatic model_push(input logic [31:0] w);
        for (int l = 0; l < 4; l++) begin
            exp_q.push_back({l[1:0], w[8*l +: 8]});
        end
    endtask

    task automatic clear_queues;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        got_par_q.delete();
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        byteStripingVLD = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b0;
        ENB   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stripedLane0    = 8'($urandom);
            byteStripingVLD = ~byteStripingVLD;
            step(1);
        end
        byteStripingVLD = 1'b0;
        n_total++; if (byteUnstripingOUT !== 8'h00) $display("FAIL reset_out got=%h exp=00", byteUnstripingOUT); else n_pass++;
        n_total++; if (byteUnstripingVLD !== 1'b0) $display("FAIL reset_vld got=%b exp=0", byteUnstripingVLD); else n_pass++;
        n_total++; if (laneIndex !== 2'd0) $display("FAIL reset_lane got=%0d exp=0", laneIndex); else n_pass++;
        n_total++; if (fifoCount !== '0) $display("FAIL reset_count got=%0d exp=0", fifoCount); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
`ifdef UNSTRIPE_PARITY_EN
        n_total++; if (parityOUT !== 1'b0) $display("FAIL reset_parity got=%b exp=0", parityOUT); else n_pass++;
`endif
        clear_queues();
        reset = 1'b1;
        step(4);
        n_total++; if (fifoCount !== '0) $display("FAIL reset_no_push_count got=%0d exp=0", fifoCount); else n_pass++;
        n_total++; if (got_q.size() != 0) $display("FAIL reset_no_bytes got=%0d exp=0", got_q.size()); else n_pass++;
    endtask

    task automatic test_single_word;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        clear_queues();
        ENB = 1'b1;
        drive_word(32'h44332211);
        step(1);                                   // edge k
        byteStripingVLD = 1'b0;
        n_total++; if (fifoCount !== CNT_W'(1)) $display("FAIL single_count_k got=%0d exp=1", fifoCount); else n_pass++;
        n_total++; if (byteUnstripingVLD !== 1'b0) $display("FAIL single_vld_k got=%b exp=0", byteUnstripingVLD); else n_pass++;
        for (int l = 0; l < 4; l++) begin
            step(1);                               // edge k+1+l
            n_total++; if (byteUnstripingOUT !== exp_b[l]) $display("FAIL single_out%0d got=%h exp=%h", l, byteUnstripingOUT, exp_b[l]); else n_pass++;
            n_total++; if (laneIndex !== 2'(l)) $display("FAIL single_lane%0d got=%0d exp=%0d", l, laneIndex, l); else n_pass++;
            n_total++; if (byteUnstripingVLD !== 1'b1) $display("FAIL single_vld%0d got=%b exp=1", l, byteUnstripingVLD); else n_pass++;
            if (l == 0) begin
                n_total++; if (fifoCount !== '0) $display("FAIL single_count_pop got=%0d exp=0", fifoCount); else n_pass++;
            end
        end
        step(1);                                   // edge k+5
        n_total++; if (byteUnstripingVLD !== 1'b0) $display("FAIL single_vld_end got=%b exp=0", byteUnstripingVLD); else n_pass++;
        n_total++; if (fifoCount !== '0) $display("FAIL single_count_end got=%0d exp=0", fifoCount); else n_pass++;
    endtask

    task automatic test_held_vld;
        int max_cnt;
        max_cnt = 0;
        clear_queues();
        ENB = 1'b1;
        drive_word(32'hA3A2A1A0);
        model_push(32'hA3A2A1A0);
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (int'(fifoCount) > max_cnt) max_cnt = int'(fifoCount);
        end
        byteStripingVLD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (int'(fifoCount) > max_cnt) max_cnt = int'(fifoCount);
        end
        n_total++; if (max_cnt > 1) $display("FAIL held_max_count got=%0d exp<=1", max_cnt); else n_pass++;
        n_total++; if (got_q.size() != 4) $display("FAIL held_nbytes got=%0d exp=4", got_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL held_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        clear_queues();
        ENB = 1'b1;
        drive_word(32'h04030201);
        model_push(32'h04030201);
        step(1);
        byteStripingVLD = 1'b0;
        step(3);
        drive_word(32'h08070605);
        model_push(32'h08070605);
        step(1);
        byteStripingVLD = 1'b0;
        step(10);
        n_total++; if (got_q.size() != 8) $display("FAIL b2b_nbytes got=%0d exp=8", got_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        for (int i = 1; i < 8 && i < got_cyc.size(); i++) begin
            n_total++; if (got_cyc[i] != got_cyc[0] + i) $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); else n_pass++;
        end
    endtask

    task automatic test_stall_overflow;
        logic [31:0] w [3];
        clear_queues();
        ENB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            drive_word(w[i]);
            if (i < DEPTH) model_push(w[i]);
            step(1);
            byteStripingVLD = 1'b0;
            step(1);
        end
        n_total++; if (fifoCount !== CNT_W'(DEPTH)) $display("FAIL stall_count got=%0d exp=%0d", fifoCount, DEPTH); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL stall_overflow got=%b exp=1", overflow); else n_pass++;
        n_total++; if (byteUnstripingVLD !== 1'b0) $display("FAIL stall_vld got=%b exp=0", byteUnstripingVLD); else n_pass++;
        n_total++; if (got_q.size() != 0) $display("FAIL stall_nbytes_stalled got=%0d exp=0", got_q.size()); else n_pass++;
        ENB = 1'b1;
        step(14);
        n_total++; if (got_q.size() != 4 * DEPTH) $display("FAIL stall_nbytes got=%0d exp=%0d", got_q.size(), 4 * DEPTH); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL stall_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL stall_overflow_sticky got=%b exp=1", overflow); else n_pass++;
        n_total++; if (fifoCount !== '0) $display("FAIL stall_count_drained got=%0d exp=0", fifoCount); else n_pass++;
    endtask

    task automatic test_reset_mid_word;
        apply_reset();
        n_total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow_clr got=%b exp=0", overflow); else n_pass++;
        clear_queues();
        ENB = 1'b1;
        drive_word(32'h44332211);
        step(1);                                   // edge k: push
        byteStripingVLD = 1'b0;
        step(1);                                   // edge k+1: 11 out
        drive_word(32'h88776655);
        step(1);                                   // edge k+2: 22 out, second push
        byteStripingVLD = 1'b0;
        n_total++; if (byteUnstripingOUT !== 8'h22) $display("FAIL midrst_pre_out got=%h exp=22", byteUnstripingOUT); else n_pass++;
        n_total++; if (laneIndex !== 2'd1) $display("FAIL midrst_pre_lane got=%0d exp=1", laneIndex); else n_pass++;
        n_total++; if (fifoCount !== CNT_W'(1)) $display("FAIL midrst_pre_count got=%0d exp=1", fifoCount); else n_pass++;
        reset = 1'b0;
        step(1);
        n_total++; if (byteUnstripingOUT !== 8'h00) $display("FAIL midrst_out got=%h exp=00", byteUnstripingOUT); else n_pass++;
        n_total++; if (byteUnstripingVLD !== 1'b0) $display("FAIL midrst_vld got=%b exp=0", byteUnstripingVLD); else n_pass++;
        n_total++; if (laneIndex !== 2'd0) $display("FAIL midrst_lane got=%0d exp=0", laneIndex); else n_pass++;
        n_total++; if (fifoCount !== '0) $display("FAIL midrst_count got=%0d exp=0", fifoCount); else n_pass++;
        reset = 1'b1;
        clear_queues();
        step(10);
        n_total++; if (got_q.size() != 0) $display("FAIL midrst_no_bytes got=%0d exp=0", got_q.size()); else n_pass++;
        n_total++; if (fifoCount !== '0) $display("FAIL midrst_count_after got=%0d exp=0", fifoCount); else n_pass++;
    endtask

`ifdef UNSTRIPE_PARITY_EN
    task automatic test_parity;
        clear_queues();
        ENB = 1'b1;
        drive_word(32'h80FF0007);
        model_push(32'h80FF0007);
        step(1);
        byteStripingVLD = 1'b0;
        step(8);
        n_total++; if (got_par_q.size() != 4) $display("FAIL parity_nbytes got=%0d exp=4", got_par_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got_par_q.size(); i++) begin
            n_total++; if (got_par_q[i] !== ^exp_q[i][7:0]) $display("FAIL parity_byte%0d got=%b exp=%b", i, got_par_q[i], ^exp_q[i][7:0]); else n_pass++;
        end
    endtask
`endif

    task automatic test_random;
        int          n_push;
        int          base;
        int          occ;
        logic [31:0] w;
        apply_reset();
        clear_queues();
        n_push = 0;
        base   = n_lane0;
        for (int c = 0; c < 600; c++) begin
            ENB = ($urandom_range(0, 3) != 0);
            occ = n_push - (n_lane0 - base);
            if (byteStripingVLD) begin
                // Sometimes hold VLD high; that must not add a word.
                if ($urandom_range(0, 2) != 0) byteStripingVLD = 1'b0;
            end else if (occ < DEPTH && $urandom_range(0, 1) == 1) begin
                w = $urandom;
                drive_word(w);
                model_push(w);
                n_push++;
            end
            step(1);
            occ = n_push - (n_lane0 - base);
            n_total++; if (fifoCount !== CNT_W'(occ)) $display("FAIL rand_count c%0d got=%0d exp=%0d", c, fifoCount, occ); else n_pass++;
            n_total++; if (overflow !== 1'b0) $display("FAIL rand_overflow c%0d got=%b exp=0", c, overflow); else n_pass++;
        end
        byteStripingVLD = 1'b0;
        ENB = 1'b1;
        step(4 * DEPTH + 12);
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL rand_nbytes got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
`ifdef UNSTRIPE_PARITY_EN
            n_total++; if (got_par_q[i] !== ^exp_q[i][7:0]) $display("FAIL rand_parity%0d got=%b exp=%b", i, got_par_q[i], ^exp_q[i][7:0]); else n_pass++;
`endif
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and final report
    // ------------------------------------------------------------------
    initial begin
        reset           = 1'b0;
        ENB             = 1'b0;
        stripedLane0    = 8'h00;
        stripedLane1    = 8'h00;
        stripedLane2    = 8'h00;
        stripedLane3    = 8'h00;
        byteStripingVLD = 1'b0;
        step(1);
        test_reset();
        test_single_word();
        test_held_vld();
        test_back_to_back();
        test_stall_overflow();
        test_reset_mid_word();
`ifdef UNSTRIPE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net against an unexpected stall of the sequence.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
